// File: rtl/axi_stream_packet_framer.sv
// axi_stream_packet_framer: rebuilds AXI-stream packet boundaries from a
// length-descriptor stream. Each accepted descriptor (length-1, cdata)
// passes that many beats of the unframed input through, flagging tlast on
// the final beat and holding cdata for the packet.
// Optional feature macro: AXI_PACKET_FRAMER_LEN_CHECK_EN (compares the
// upstream s_axis_tlast with the generated tlast and sets sticky len_err).
module axi_stream_packet_framer #(
  parameter int DSIZE = 24,
  parameter int CSIZE = 1,
  parameter int LSIZE = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             len_tvalid,
  output logic             len_tready,
  input  logic [LSIZE-1:0] len_tdata,
  input  logic [CSIZE-1:0] in_cdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [DSIZE-1:0] s_axis_tdata,
  input  logic             s_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [DSIZE-1:0] m_axis_tdata,
  output logic             m_axis_tlast,
  output logic [CSIZE-1:0] out_cdata,
  output logic             len_err
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state, state_nxt;
  logic [LSIZE-1:0] len_q, len_q_nxt;
  logic [LSIZE-1:0] cnt, cnt_nxt;
  logic [CSIZE-1:0] cdata_nxt;
  logic             in_stream;
  logic             out_hs, last_hs, len_hs;

  // Data path is a gated pass-through; everything is held off while in reset
  // so a mid-packet reset cannot leak a beat or a tlast.
  assign in_stream     = aresetn && (state == STREAM);
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = in_stream && s_axis_tvalid;
  assign s_axis_tready = in_stream && m_axis_tready;
  assign m_axis_tlast  = in_stream && (cnt == len_q);
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign last_hs       = out_hs && m_axis_tlast;
  // Accepting the next descriptor on the last beat keeps packets back to back.
  assign len_tready    = aresetn && ((state == IDLE) || last_hs);
  assign len_hs        = len_tvalid && len_tready;

  // State, beat counter, captured length and control data.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      out_cdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      len_q     <= len_q_nxt;
      out_cdata <= cdata_nxt;
    end
  end

  // Next-state: start a packet on a descriptor, count beats, chain or stop
  // on the last beat.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_q_nxt = len_q;
    cdata_nxt = out_cdata;
    unique case (state)
      IDLE: begin
        if (len_hs) begin
          state_nxt = STREAM;
          cnt_nxt   = '0;
          len_q_nxt = len_tdata;
          cdata_nxt = in_cdata;
        end
      end
      STREAM: begin
        if (last_hs) begin
          if (len_hs) begin
            cnt_nxt   = '0;
            len_q_nxt = len_tdata;
            cdata_nxt = in_cdata;
          end else begin
            state_nxt = IDLE;
          end
        end else if (out_hs) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AXI_PACKET_FRAMER_LEN_CHECK_EN
  // Sticky flag: upstream boundary disagrees with the descriptor framing.
  always_ff @(posedge aclk) begin
    if (!aresetn)
      len_err <= 1'b0;
    else if (out_hs && (s_axis_tlast != m_axis_tlast))
      len_err <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign len_err      = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_packet_framer.sv
// Scoreboard bench for axi_stream_packet_framer: directed tests push the
// expected output beats into a queue; a monitor pops and compares on every
// output handshake.
module tb_axi_stream_packet_framer;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic        len_tvalid, len_tready;
  logic [15:0] len_tdata;
  logic [0:0]  in_cdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [23:0] s_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [23:0] m_axis_tdata;
  logic [0:0]  out_cdata;
  logic        len_err;

  axi_stream_packet_framer #(.DSIZE(24), .CSIZE(1), .LSIZE(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .len_tvalid(len_tvalid), .len_tready(len_tready), .len_tdata(len_tdata),
    .in_cdata(in_cdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .out_cdata(out_cdata), .len_err(len_err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [23:0] data;
    logic        last;
    logic        cd;
  } exp_t;

  exp_t exp_q[$];
  int   hs_cyc[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  logic bp_done;

  always @(posedge aclk) cyc <= cyc + 1;

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge aclk) begin
    exp_t e;
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_beat: got data=%h last=%b cd=%b, expected none",
                 m_axis_tdata, m_axis_tlast, out_cdata);
      end else begin
        e = exp_q.pop_front();
        if (m_axis_tdata !== e.data || m_axis_tlast !== e.last || out_cdata !== e.cd) begin
          nerr++;
          $display("FAIL beat: got data=%h last=%b cd=%b, expected data=%h last=%b cd=%b",
                   m_axis_tdata, m_axis_tlast, out_cdata, e.data, e.last, e.cd);
        end
      end
      hs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [23:0] d, input logic l, input logic c);
    exp_t e;
    e.data = d; e.last = l; e.cd = c;
    exp_q.push_back(e);
  endtask

  // Present a descriptor and hold it until accepted; returns handshake cycle.
  task automatic send_desc(input logic [15:0] len, input logic cd, output int hc);
    int t = 0;
    len_tvalid = 1'b1; len_tdata = len; in_cdata = cd;
    @(negedge aclk);
    while (!len_tready && t < 200) begin @(negedge aclk); t++; end
    hc = cyc;
    if (t >= 200) begin
      nvec++; nerr++;
      $display("FAIL desc_timeout: got no len_tready, expected accept");
    end
    @(posedge aclk); #1;
    len_tvalid = 1'b0;
  endtask

  // Present one data beat and hold it until accepted.
  task automatic send_beat(input logic [23:0] d, input logic tl);
    int t = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = tl;
    @(negedge aclk);
    while (!s_axis_tready && t < 200) begin @(negedge aclk); t++; end
    if (t >= 200) begin
      nvec++; nerr++;
      $display("FAIL beat_timeout: got no s_axis_tready, expected accept");
    end
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge aclk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int dc, dc2;
    aresetn = 1'b0; len_tvalid = 1'b0; len_tdata = '0; in_cdata = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1; bp_done = 1'b0;

    // Reset state
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b1; len_tvalid = 1'b1;
    @(negedge aclk);
    check("rst_len_tready", len_tready, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_cdata", out_cdata, 0);
    check("rst_len_err", len_err, 0);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0; len_tvalid = 1'b0; aresetn = 1'b1;
    @(posedge aclk); #1;

    // Single packet: len=3, cdata=1, data A..D
    push(24'hA, 0, 1); push(24'hB, 0, 1); push(24'hC, 0, 1); push(24'hD, 1, 1);
    fork
      send_desc(16'd3, 1'b1, dc);
      begin send_beat(24'hA, 0); send_beat(24'hB, 0); send_beat(24'hC, 0); send_beat(24'hD, 0); end
    join
    drain("single_drain");
    check("single_cdata_hold", out_cdata, 1);

    // Back-to-back: len=0 (cd=0) then len=1 (cd=1), continuous data
    hs_cyc.delete();
    push(24'h11, 1, 0); push(24'h22, 0, 1); push(24'h33, 1, 1);
    fork
      begin send_desc(16'd0, 1'b0, dc); send_desc(16'd1, 1'b1, dc2); end
      begin send_beat(24'h11, 0); send_beat(24'h22, 0); send_beat(24'h33, 0); end
    join
    drain("b2b_drain");
    check("b2b_nbeats", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      check("b2b_first_latency", hs_cyc[0] - dc, 1);
      check("b2b_desc2_on_last", dc2, hs_cyc[0]);
      check("b2b_gap1", hs_cyc[1] - hs_cyc[0], 1);
      check("b2b_gap2", hs_cyc[2] - hs_cyc[1], 1);
    end

    // Backpressure: len=7, m_axis_tready toggling every cycle
    for (int i = 0; i < 8; i++) push(24'h100 + 24'(i), (i == 7), 0);
    bp_done = 1'b0;
    fork
      send_desc(16'd7, 1'b0, dc);
      begin for (int i = 0; i < 8; i++) send_beat(24'h100 + 24'(i), 0); bp_done = 1'b1; end
      while (!bp_done) begin @(posedge aclk); #1; m_axis_tready = ~m_axis_tready; end
    join
    m_axis_tready = 1'b1;
    drain("bp_drain");

    // Early data: valid for 5 cycles with no descriptor
    hs_cyc.delete();
    s_axis_tvalid = 1'b1; s_axis_tdata = 24'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("early_s_tready", s_axis_tready, 0);
      check("early_m_tvalid", m_axis_tvalid, 0);
    end
    @(posedge aclk); #1;
    push(24'h55, 0, 1); push(24'h66, 1, 1);
    fork
      send_desc(16'd1, 1'b1, dc);
      begin send_beat(24'h55, 0); send_beat(24'h66, 0); end
    join
    drain("early_drain");
    if (hs_cyc.size() > 0) check("early_latency", hs_cyc[0] - dc, 1);

    // Reset mid-packet: len=9, reset after 4 beats
    for (int i = 0; i < 4; i++) push(24'h70 + 24'(i), 0, 1);
    fork
      send_desc(16'd9, 1'b1, dc);
      begin for (int i = 0; i < 4; i++) send_beat(24'h70 + 24'(i), 0); end
    join
    s_axis_tvalid = 1'b1; s_axis_tdata = 24'h74; aresetn = 1'b0;
    @(negedge aclk);
    check("midrst_m_tvalid", m_axis_tvalid, 0);
    check("midrst_m_tlast", m_axis_tlast, 0);
    check("midrst_len_tready", len_tready, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("postrst_s_tready", s_axis_tready, 0);
    check("postrst_m_tvalid", m_axis_tvalid, 0);
    check("postrst_m_tlast", m_axis_tlast, 0);
    check("postrst_cdata", out_cdata, 0);
    check("postrst_idle_len_tready", len_tready, 1);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    push(24'h80, 0, 0); push(24'h81, 1, 0);
    fork
      send_desc(16'd1, 1'b0, dc);
      begin send_beat(24'h80, 0); send_beat(24'h81, 0); end
    join
    drain("postrst_drain");

    // Upstream tlast disagreeing with the descriptor
    push(24'h90, 0, 1); push(24'h91, 0, 1); push(24'h92, 1, 1);
    fork
      send_desc(16'd2, 1'b1, dc);
      begin
        send_beat(24'h90, 0); send_beat(24'h91, 1);
`ifdef AXI_PACKET_FRAMER_LEN_CHECK_EN
        @(negedge aclk);
        check("len_err_set", len_err, 1);
`endif
        send_beat(24'h92, 0);
      end
    join
    drain("lenchk_drain");
`ifdef AXI_PACKET_FRAMER_LEN_CHECK_EN
    check("len_err_sticky", len_err, 1);
`else
    check("len_err_tied", len_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_stream_packet_framer.md
# axi_stream_packet_framer

Single-clock AXI-stream framer that rebuilds packet boundaries from a length-descriptor stream. For each accepted descriptor (beat count plus side-band control data) it passes exactly that many beats of an unframed data stream to the output, asserts `m_axis_tlast` on the final beat and holds the control data for the whole packet. It sits downstream of blocks that split framed traffic into raw data plus length records, and restores framed AXI-stream packets.

## Interface
Parameters:
- `DSIZE`, 24: data width.
- `CSIZE`, 1: side-band control data width.
- `LSIZE`, 16: descriptor length field width.

Ports (clock and reset first):
- `aclk` input 1: single clock for all logic.
- `aresetn` input 1: reset, synchronous, active-low.
- `len_tvalid` input 1: descriptor valid.
- `len_tready` output 1: descriptor accept.
- `len_tdata` input LSIZE: packet length in beats minus 1; 0 means a 1-beat packet.
- `in_cdata` input CSIZE: control data, qualified with the descriptor.
- `s_axis_tvalid` input 1: unframed data valid.
- `s_axis_tready` output 1: unframed data ready.
- `s_axis_tdata` input DSIZE: unframed data.
- `s_axis_tlast` input 1: optional upstream boundary. Used only with `AXI_PACKET_FRAMER_LEN_CHECK_EN` defined.
- `m_axis_tvalid` output 1: framed data valid.
- `m_axis_tready` input 1: framed data ready.
- `m_axis_tdata` output DSIZE: framed data, equal to `s_axis_tdata`.
- `m_axis_tlast` output 1: generated end of packet.
- `out_cdata` output CSIZE: control data of the current packet.
- `len_err` output 1: sticky length-mismatch flag.

## Operation
- FSM states:
  - IDLE: waiting for a descriptor.
  - STREAM: packet in flight.
- Registers:
  - `len_q` (LSIZE bits): captured from `len_tdata` on the descriptor handshake.
  - `cnt` (LSIZE bits): beats already sent in the current packet.
  - `out_cdata`: captured from `in_cdata` on the descriptor handshake.
- `len_tready = aresetn && (state==IDLE || last_hs)`, where `last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast`.
  - Back-to-back packets therefore need no idle cycle between them.
- Data path is combinational pass-through, gated by state:
  - `m_axis_tvalid = state==STREAM && s_axis_tvalid`.
  - `s_axis_tready = state==STREAM && m_axis_tready`.
- `m_axis_tlast = state==STREAM && cnt==len_q`.
- IDLE transitions:
  - Descriptor handshake: go to STREAM, `cnt<=0`, capture `len_q` and `out_cdata`.
- STREAM transitions:
  - Non-last beat handshake: `cnt<=cnt+1`.
  - Last beat handshake with no descriptor handshake in the same cycle: go to IDLE.
  - Last beat handshake with a descriptor handshake in the same cycle: stay in STREAM, `cnt<=0`, capture the new `len_q` and `out_cdata`.
- `out_cdata` holds its value after the packet ends, until the next descriptor is accepted.
- Counter arithmetic is LSIZE-bit unsigned. `cnt` never exceeds `len_q`, so it never wraps. The maximum packet is 2^LSIZE beats.
- No data beats are consumed in IDLE. Data arriving early waits, with `s_axis_tready=0`.

## Timing
- Zero-cycle data latency: `s_axis_*` to `m_axis_*` is combinational.
- Descriptor-to-first-beat latency: 1 cycle. The first beat can complete on the cycle after the descriptor handshake.
- Sustained throughput: 1 beat per cycle, including across packet boundaries.
- There is a combinational path from `m_axis_tready` to `len_tready` and to `s_axis_tready`.
- Reset (synchronous, sampled at `posedge aclk` with `aresetn=0`):
  - State goes to IDLE.
  - `cnt`, `len_q`, `out_cdata` and `len_err` go to 0.
  - While `aresetn=0`, `len_tready`, `s_axis_tready`, `m_axis_tvalid` and `m_axis_tlast` are 0.
- Reset mid-packet abandons the remainder of the packet. No `tlast` is generated for it.
- Stall behaviour:
  - `m_axis_tready=0` holds `cnt` and the state.
  - `s_axis_tvalid=0` in STREAM drops `m_axis_tvalid`; no beat is counted.

## Configuration
- `AXI_PACKET_FRAMER_LEN_CHECK_EN` defined:
  - On every output handshake, `s_axis_tlast != m_axis_tlast` sets `len_err<=1`.
  - `len_err` stays set until reset.
  - Framing always follows the descriptor; `s_axis_tlast` never alters `m_axis_tlast`.
- `AXI_PACKET_FRAMER_LEN_CHECK_EN` not defined:
  - `s_axis_tlast` is ignored.
  - `len_err` is tied to 0.
  - No check logic is built.

## Test plan
- Single packet: descriptor len=3, cdata=1, data 0xA..0xD with `m_axis_tready=1` -> 4 output beats; `m_axis_tlast` only on 0xD; `out_cdata=1` throughout the packet.
- Back-to-back: descriptors len=0 then len=1, data streaming continuously -> beats out on consecutive cycles; `m_axis_tlast` on beats 1 and 3; second descriptor accepted in the same cycle as the first packet's last beat.
- Backpressure: len=7, `m_axis_tready` toggling every cycle -> exactly 8 beats in order; `tlast` on the 8th; no duplicated or dropped beats.
- Early data: `s_axis_tvalid=1` for 5 cycles before any descriptor -> `s_axis_tready=0` and `m_axis_tvalid=0` until 1 cycle after the descriptor handshake.
- Reset mid-packet: len=9, `aresetn=0` after 4 beats -> next cycle in IDLE with all outputs 0; a new len=1 packet then frames correctly.
- With `AXI_PACKET_FRAMER_LEN_CHECK_EN`: len=2 with `s_axis_tlast` on beat 2 -> `len_err=1` after that handshake, still 1 after the packet; `tlast` still on beat 3.
